cache_ref_sequencer: RTL



---
 rtl/cache_ref_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cache_ref_sequencer.sv
// Reference sequencer for the 16-set cache model: buffers incoming references,
// steps each through lookup (and a fill on miss), and keeps hit/miss statistics.
module cache_ref_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_valid,
  input  logic [31:0]      ref_addr,
  output logic             ref_ready,
  input  logic             trace_end,
  input  logic             cache_hit,
  output logic [31:0]      cache_addr,
  output logic             cache_state,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] ref_count,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [31:0]      mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r, count_nxt_s;
  logic             end_flag_r;
  logic             ref_ready_r;
  logic             done_r;
  logic             cache_state_r;
  logic [31:0]      cache_addr_r;
  logic [CNT_W-1:0] hit_r, miss_r, ref_r;
  logic             push_s, pop_s, empty_s;
  logic             hit_inc_s, miss_inc_s, ref_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  assign push_s  = ref_valid && ref_ready_r;
  assign empty_s = (count_r == {(AW+1){1'b0}});

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Sequencer next state and per-cycle pop/statistics strobes.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    hit_inc_s   = 1'b0;
    miss_inc_s  = 1'b0;
    ref_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = LOOKUP;
        end else if (end_flag_r) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOOKUP: begin
        if (cache_hit) begin
          hit_inc_s = 1'b1;
          ref_inc_s = 1'b1;
          // A hit chains straight into the next queued reference.
          if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = LOOKUP;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          miss_inc_s  = 1'b1;
          state_nxt_s = FILL;
        end
      end
      FILL: begin
        ref_inc_s   = 1'b1;
        state_nxt_s = IDLE;
      end
      DONE: begin
        state_nxt_s = DONE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FIFO storage; stale entries are harmless because pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= ref_addr;
    end
  end

  // Control state, FIFO pointers, statistics and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= {(AW+1){1'b0}};
      end_flag_r    <= 1'b0;
      ref_ready_r   <= 1'b1;
      done_r        <= 1'b0;
      cache_state_r <= 1'b0;
      cache_addr_r  <= 32'h0000_0000;
      hit_r         <= {CNT_W{1'b0}};
      miss_r        <= {CNT_W{1'b0}};
      ref_r         <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r     <= rd_ptr_r + AW'(1);
        cache_addr_r <= mem_r[rd_ptr_r];
      end
      if (trace_end) begin
        end_flag_r <= 1'b1;
      end
      if (hit_inc_s) begin
        hit_r <= sat_inc(hit_r);
      end
      if (miss_inc_s) begin
        miss_r <= sat_inc(miss_r);
      end
      if (ref_inc_s) begin
        ref_r <= sat_inc(ref_r);
      end
      cache_state_r <= (state_nxt_s == FILL);
      done_r        <= (state_nxt_s == DONE);
      ref_ready_r   <= (count_nxt_s != FULL_C) && (state_nxt_s != DONE);
    end
  end

  assign ref_ready   = ref_ready_r;
  assign cache_addr  = cache_addr_r;
  assign cache_state = cache_state_r;
  assign hit_count   = hit_r;
  assign miss_count  = miss_r;
  assign ref_count   = ref_r;
  assign done        = done_r;

endmodule
